wb_sram_pipe: RTL and testbench

//  Wishbone B4 slave wrapping one sram_1r1w macro; successor to the single-cycle classic SRAM slave.

---
 rtl/wb_sram_pipe_pkg.sv | 30 +++
 rtl/wb_sram_pipe_resp.sv | 94 +++++++++
 rtl/wb_sram_pipe_sram.sv | 52 +++++
 rtl/wb_sram_pipe.sv | 139 +++++++++++++
 tb/tb_wb_sram_pipe.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sram_pipe_pkg.sv
// ---------------------------------------------------------------------------
// wb_sram_pipe_pkg
// Shared definitions for the Wishbone SRAM slave:
//   MAX_LATENCY  - deepest supported response latency
//   resp_e       - response kind presented on the bus (none / ack / err)
//   resp_tag_t   - per-request bookkeeping carried down the response pipe
//   lsb_bits()   - number of byte-offset address bits for a given strobe width
// ---------------------------------------------------------------------------
package wb_sram_pipe_pkg;

    localparam int unsigned MAX_LATENCY = 4;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef struct packed {
        logic valid;
        logic is_err;
        logic is_read;
    } resp_tag_t;

    // Byte-offset bits of a Wishbone address (0 for an 8-bit bus).
    function automatic int unsigned lsb_bits(input int unsigned strobe_width);
        return $clog2(strobe_width);
    endfunction

endpackage

// File: rtl/wb_sram_pipe_resp.sv
// ---------------------------------------------------------------------------
// wb_sram_pipe_resp
// Response pipeline of the Wishbone SRAM slave. A depth-stage shift register
// of request tags {valid, is_err, is_read}, plus (depth-1) data registers
// that delay the SRAM read data (already one cycle late) so it lines up with
// the tag leaving the last stage. flush clears every tag on the next edge;
// reset clears them immediately.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   flush     in   drop every outstanding request (bus cycle ended)
//   in_tag    in   tag of the request accepted this cycle (valid=0 if none)
//   rd_data   in   SRAM dout
//   out_tag   out  tag whose response is due this cycle
//   out_data  out  read data belonging to out_tag
//   busy      out  any tag held in the pipe (outstanding or being presented)
// ---------------------------------------------------------------------------
module wb_sram_pipe_resp
    import wb_sram_pipe_pkg::*;
#(
    parameter int unsigned depth      = 1,
    parameter int unsigned data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  resp_tag_t             in_tag,
    input  logic [data_width-1:0] rd_data,
    output resp_tag_t             out_tag,
    output logic [data_width-1:0] out_data,
    output logic                  busy
);

    resp_tag_t [depth-1:0] tag_q;
    resp_tag_t [depth-1:0] tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = in_tag;
        for (int i = 1; i < int'(depth); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (flush) begin
            tag_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(depth); i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    assign out_tag = tag_q[depth-1];

    // SRAM data is valid one cycle after the access; a latency-1 response
    // uses it directly, longer latencies carry it through extra registers.
    generate
        if (depth == 1) begin : g_no_delay
            assign out_data = rd_data;
        end else begin : g_delay
            logic [depth-2:0][data_width-1:0] data_q;
            logic [depth-2:0][data_width-1:0] data_d;

            always_comb begin
                data_d    = data_q;
                data_d[0] = rd_data;
                for (int i = 1; i < int'(depth) - 1; i++) begin
                    data_d[i] = data_q[i-1];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign out_data = data_q[depth-2];
        end
    endgenerate

endmodule

// File: rtl/wb_sram_pipe_sram.sv
// ---------------------------------------------------------------------------
// sram_1r1w
// Behavioural model of the single-access SRAM macro (inferred block RAM).
// One access per cycle when en is high: a write stores the byte lanes selected
// by wmask, a read returns the addressed word on dout one cycle later. A write
// in cycle n is visible to a read in cycle n+1.
// Ports:
//   clock  in   rising-edge clock
//   en     in   access enable
//   we     in   1 = write, 0 = read
//   addr   in   word address
//   wmask  in   byte-lane write enables
//   din    in   write data
//   dout   out  read data, registered
// ---------------------------------------------------------------------------
module sram_1r1w #(
    parameter int unsigned addr_width   = 8,
    parameter int unsigned data_width   = 32,
    parameter int unsigned strobe_width = data_width / 8
) (
    input  logic                    clock,
    input  logic                    en,
    input  logic                    we,
    input  logic [addr_width-1:0]   addr,
    input  logic [strobe_width-1:0] wmask,
    input  logic [data_width-1:0]   din,
    output logic [data_width-1:0]   dout
);

    localparam int unsigned depth = 2 ** addr_width;

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] dout_q;

    // Memory arrays carry no reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(strobe_width); i++) begin
                    if (wmask[i]) begin
                        mem_q[addr][i*8 +: 8] <= din[i*8 +: 8];
                    end
                end
            end else begin
                dout_q <= mem_q[addr];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/wb_sram_pipe.sv
// ---------------------------------------------------------------------------
// wb_sram_pipe
// Wishbone B4 slave in front of one sram_1r1w macro, used as on-chip RAM.
// Pipelined mode accepts one request per cycle; classic mode keeps a single
// request in flight. Every accepted request gets exactly one ack (in-range)
// or err (out-of-range) read_latency cycles after acceptance, in order.
// Dropping wb_cyc discards all outstanding responses.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   wb_adr    in   byte address
//   wb_datwr  in   write data
//   wb_datrd  out  read data, non-zero only alongside wb_ack of a read
//   wb_we     in   1 = write
//   wb_stb    in   strobe
//   wb_cyc    in   bus cycle
//   wb_sel    in   byte-lane write enables
//   wb_ack    out  normal termination
//   wb_err    out  error termination (address outside the RAM window)
//   wb_stall  out  request not accepted this cycle
// ---------------------------------------------------------------------------
module wb_sram_pipe
    import wb_sram_pipe_pkg::*;
#(
    parameter int unsigned          addr_width      = 32,
    parameter int unsigned          data_width      = 32,
    parameter int unsigned          strobe_width    = data_width / 8,
    parameter int unsigned          sram_addr_width = 8,
    parameter logic [addr_width-1:0] base_addr      = '0,
    parameter int unsigned          read_latency    = 1,
    parameter bit                   pipelined       = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [addr_width-1:0]   wb_adr,
    input  logic [data_width-1:0]   wb_datwr,
    output logic [data_width-1:0]   wb_datrd,
    input  logic                    wb_we,
    input  logic                    wb_stb,
    input  logic                    wb_cyc,
    input  logic [strobe_width-1:0] wb_sel,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_stall
);

    localparam int unsigned lsb      = lsb_bits(strobe_width);
    localparam int unsigned off_bits = sram_addr_width + lsb;
    // Ones over the byte offset within the RAM window.
    localparam logic [addr_width-1:0] off_mask =
        {addr_width{1'b1}} >> (addr_width - off_bits);

    // ---------------- elaboration-time parameter checks ----------------
    generate
        if (read_latency < 1 || read_latency > MAX_LATENCY) begin : g_bad_latency
            $error("wb_sram_pipe: read_latency must be in 1..4");
        end
        if (off_bits > addr_width) begin : g_bad_width
            $error("wb_sram_pipe: SRAM window larger than the address space");
        end
        if ((base_addr & off_mask) != '0) begin : g_bad_base
            $error("wb_sram_pipe: base_addr not aligned to the SRAM size");
        end
        if (data_width != strobe_width * 8) begin : g_bad_strobe
            $error("wb_sram_pipe: data_width must equal 8*strobe_width");
        end
    endgenerate

    // ---------------- request decode ----------------
    logic                       in_range;
    logic                       accept;
    logic                       sram_en;
    logic [sram_addr_width-1:0] word_idx;
    logic [data_width-1:0]      sram_dout;
    resp_tag_t                  in_tag;
    resp_tag_t                  out_tag;
    logic [data_width-1:0]      out_data;
    logic                       busy;
    resp_e                      resp_kind;

    assign word_idx = wb_adr[lsb +: sram_addr_width];
    assign in_range = (wb_adr & ~off_mask) == base_addr;
    assign accept   = wb_cyc & wb_stb & ~wb_stall;
    // Out-of-range requests still occupy a response slot but never touch RAM.
    assign sram_en  = accept & in_range;

    always_comb begin
        in_tag         = '0;
        in_tag.valid   = accept;
        in_tag.is_err  = ~in_range;
        in_tag.is_read = ~wb_we;
    end

    // Classic mode holds off the next request until the current response has
    // been presented, so at most one request is ever in flight.
    assign wb_stall = pipelined ? 1'b0 : busy;

    sram_1r1w #(
        .addr_width   (sram_addr_width),
        .data_width   (data_width),
        .strobe_width (strobe_width)
    ) u_sram (
        .clock (clock),
        .en    (sram_en),
        .we    (wb_we),
        .addr  (word_idx),
        .wmask (wb_sel),
        .din   (wb_datwr),
        .dout  (sram_dout)
    );

    wb_sram_pipe_resp #(
        .depth      (read_latency),
        .data_width (data_width)
    ) u_resp (
        .clock    (clock),
        .reset    (reset),
        .flush    (~wb_cyc),
        .in_tag   (in_tag),
        .rd_data  (sram_dout),
        .out_tag  (out_tag),
        .out_data (out_data),
        .busy     (busy)
    );

    // ---------------- response presentation ----------------
    // Gating with wb_cyc keeps a response off the bus in the very cycle the
    // master abandons the transfer; the flush removes it on the next edge.
    always_comb begin
        resp_kind = RESP_NONE;
        if (out_tag.valid && wb_cyc) begin
            resp_kind = out_tag.is_err ? RESP_ERR : RESP_ACK;
        end
        wb_ack   = (resp_kind == RESP_ACK);
        wb_err   = (resp_kind == RESP_ERR);
        wb_datrd = (wb_ack && out_tag.is_read) ? out_data : '0;
    end

endmodule

// File: tb/tb_wb_sram_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_pipe
// Two instances: u_pipe (pipelined, latency 3, RAM window at 0x1000) and
// u_classic (classic, latency 1, window at 0). The pipelined instance is
// checked every cycle against a reference model: a word array for memory and
// a queue of expected responses, each due LAT_A cycles after acceptance.
// ---------------------------------------------------------------------------
module tb_wb_sram_pipe;

    localparam int unsigned LAT_A  = 3;
    localparam logic [31:0] BASE_A = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // pipelined instance bus
    logic [31:0] a_adr, a_datwr, a_datrd;
    logic        a_we, a_stb, a_cyc, a_ack, a_err, a_stall;
    logic [3:0]  a_sel;
    // classic instance bus
    logic [31:0] b_adr, b_datwr, b_datrd;
    logic        b_we, b_stb, b_cyc, b_ack, b_err, b_stall;
    logic [3:0]  b_sel;

    wb_sram_pipe #(
        .addr_width(32), .data_width(32), .strobe_width(4), .sram_addr_width(8),
        .base_addr(BASE_A), .read_latency(LAT_A), .pipelined(1'b1)
    ) u_pipe (
        .clock(clk), .reset(rst), .wb_adr(a_adr), .wb_datwr(a_datwr), .wb_datrd(a_datrd),
        .wb_we(a_we), .wb_stb(a_stb), .wb_cyc(a_cyc), .wb_sel(a_sel),
        .wb_ack(a_ack), .wb_err(a_err), .wb_stall(a_stall)
    );

    wb_sram_pipe #(
        .addr_width(32), .data_width(32), .strobe_width(4), .sram_addr_width(4),
        .base_addr(32'h0), .read_latency(1), .pipelined(1'b0)
    ) u_classic (
        .clock(clk), .reset(rst), .wb_adr(b_adr), .wb_datwr(b_datwr), .wb_datrd(b_datrd),
        .wb_we(b_we), .wb_stb(b_stb), .wb_cyc(b_cyc), .wb_sel(b_sel),
        .wb_ack(b_ack), .wb_err(b_err), .wb_stall(b_stall)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [256];
    int unsigned cyc_no     = 0;
    int unsigned n_ack_seen = 0;
    int unsigned n_err_seen = 0;
    logic [31:0] last_rd    = '0;

    task automatic set_a(input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        a_cyc = cyc; a_stb = stb; a_we = we; a_adr = adr; a_datwr = dat; a_sel = sel;
    endtask

    task automatic set_b(input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        b_cyc = cyc; b_stb = stb; b_we = we; b_adr = adr; b_datwr = dat; b_sel = sel;
    endtask

    // One bus cycle of the pipelined instance: called at posedge+1 with inputs
    // already driven; checks outputs mid-cycle, updates the model, advances.
    task automatic step_a();
        exp_t        e;
        bit          exp_ack;
        bit          exp_err;
        logic [31:0] exp_dat;
        bit          in_rng;
        int unsigned widx;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = '0;
        @(negedge clk);
        if (!a_cyc) begin
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc_no) begin
            e       = exp_q.pop_front();
            exp_ack = !e.is_err;
            exp_err = e.is_err;
            exp_dat = (exp_ack && e.is_read) ? e.data : 32'h0;
        end
        check("a_ack",   32'(a_ack),   32'(exp_ack));
        check("a_err",   32'(a_err),   32'(exp_err));
        check("a_datrd", a_datrd,      exp_dat);
        check("a_stall", 32'(a_stall), 32'h0);
        if (a_ack) begin
            n_ack_seen++;
            last_rd = a_datrd;
        end
        if (a_err) n_err_seen++;
        if (a_cyc && a_stb) begin
            in_rng    = (a_adr >> 10) == (BASE_A >> 10);
            widx      = (a_adr >> 2) & 32'hFF;
            e.due     = cyc_no + LAT_A;
            e.is_err  = !in_rng;
            e.is_read = !a_we;
            e.data    = ref_mem[widx];
            if (in_rng && a_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (a_sel[b]) ref_mem[widx][b*8 +: 8] = a_datwr[b*8 +: 8];
                end
            end
            exp_q.push_back(e);
            $display("txn a cyc=%0d %s adr=%h wdat=%h sel=%h resp=%s",
                     cyc_no, a_we ? "WR" : "RD", a_adr, a_datwr, a_sel, in_rng ? "ack" : "err");
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic idle_a(input int n);
        set_a(1'b1, 1'b0, 1'b0, BASE_A, 32'h0, 4'h0);
        for (int i = 0; i < n; i++) step_a();
    endtask

    initial begin
        int unsigned acks0;
        int unsigned errs0;
        set_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_b(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ack",   32'(a_ack),   32'h0);
        check("rst_a_err",   32'(a_err),   32'h0);
        check("rst_a_stall", 32'(a_stall), 32'h0);
        check("rst_a_datrd", a_datrd,      32'h0);
        check("rst_b_stall", 32'(b_stall), 32'h0);
        check("rst_b_datrd", b_datrd,      32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- fill the whole RAM so every later read has a defined value ----
        for (int w = 0; w < 256; w++) begin
            set_a(1'b1, 1'b1, 1'b1, BASE_A + 32'(w) * 4, $urandom, 4'hF);
            step_a();
        end
        idle_a(LAT_A + 1);

        // ---- full write then read back ----
        set_a(1'b1, 1'b1, 1'b1, BASE_A + 32'h10, 32'hDEAD_BEEF, 4'hF); step_a();
        set_a(1'b1, 1'b1, 1'b0, BASE_A + 32'h10, 32'h0, 4'h0);        step_a();
        idle_a(LAT_A + 1);
        check("rd_deadbeef", last_rd, 32'hDEAD_BEEF);

        // ---- single byte lane write ----
        set_a(1'b1, 1'b1, 1'b1, BASE_A + 32'h10, 32'h0000_00AA, 4'h1); step_a();
        set_a(1'b1, 1'b1, 1'b0, BASE_A + 32'h10, 32'h0, 4'h0);         step_a();
        idle_a(LAT_A + 1);
        check("rd_byte_merge", last_rd, 32'hDEAD_BEAA);

        // ---- sel=0 write leaves memory unchanged ----
        set_a(1'b1, 1'b1, 1'b1, BASE_A + 32'h10, 32'hFFFF_FFFF, 4'h0); step_a();
        set_a(1'b1, 1'b1, 1'b0, BASE_A + 32'h10, 32'h0, 4'h0);         step_a();
        idle_a(LAT_A + 1);
        check("rd_sel0", last_rd, 32'hDEAD_BEAA);

        // ---- four back-to-back reads ----
        acks0 = n_ack_seen;
        for (int k = 0; k < 4; k++) begin
            set_a(1'b1, 1'b1, 1'b0, BASE_A + 32'(k) * 4, 32'h0, 4'h0);
            step_a();
        end
        idle_a(LAT_A + 1);
        check("b2b_ack_count", n_ack_seen - acks0, 32'd4);

        // ---- out-of-range write: one err, no ack, RAM untouched ----
        acks0 = n_ack_seen;
        errs0 = n_err_seen;
        set_a(1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h5555_5555, 4'hF); step_a();
        idle_a(LAT_A + 1);
        check("oor_err_count", n_err_seen - errs0, 32'd1);
        check("oor_ack_count", n_ack_seen - acks0, 32'd0);
        set_a(1'b1, 1'b1, 1'b0, BASE_A, 32'h0, 4'h0); step_a();
        idle_a(LAT_A + 1);
        check("oor_mem_kept", last_rd, ref_mem[0]);

        // ---- cyc dropped one cycle after an out-of-range accept ----
        errs0 = n_err_seen;
        set_a(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0); step_a();
        set_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) step_a();
        idle_a(LAT_A + 1);
        check("cyc_drop_no_err", n_err_seen - errs0, 32'd0);

        // ---- reset while a read response is on the bus ----
        set_a(1'b1, 1'b1, 1'b0, BASE_A + 32'h10, 32'h0, 4'h0); step_a();
        idle_a(LAT_A - 1);
        check("rst_mid_pre_ack", 32'(a_ack), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ack",   32'(a_ack),   32'h0);
        check("rst_mid_err",   32'(a_err),   32'h0);
        check("rst_mid_datrd", a_datrd,      32'h0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc_no++;
        acks0 = n_ack_seen;
        idle_a(LAT_A + 2);
        check("rst_mid_no_late_ack", n_ack_seen - acks0, 32'd0);

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            logic [31:0] adr;
            if ($urandom_range(0, 4) == 0) adr = $urandom;
            else adr = BASE_A + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
            set_a($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
                  adr, $urandom, 4'($urandom_range(0, 15)));
            step_a();
        end
        idle_a(LAT_A + 1);
        check("drain_empty", 32'(exp_q.size()), 32'h0);
        set_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // ---- classic mode, latency 1: stb held four cycles ----
        set_b(1'b1, 1'b1, 1'b1, 32'h0, 32'h1122_3344, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cl_wr_ack",   32'(b_ack),   32'(k % 2));
            check("cl_wr_stall", 32'(b_stall), 32'(k % 2));
            check("cl_wr_datrd", b_datrd,      32'h0);
            $display("txn b cyc=%0d WR ack=%0b stall=%0b", k, b_ack, b_stall);
            @(posedge clk);
            #1;
        end
        set_b(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cl_rd_ack",   32'(b_ack),   32'(k % 2));
            check("cl_rd_err",   32'(b_err),   32'h0);
            check("cl_rd_stall", 32'(b_stall), 32'(k % 2));
            check("cl_rd_datrd", b_datrd,      (k % 2 == 1) ? 32'h1122_3344 : 32'h0);
            $display("txn b cyc=%0d RD ack=%0b stall=%0b datrd=%h", k, b_ack, b_stall, b_datrd);
            @(posedge clk);
            #1;
        end
        set_b(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
